ex_mem_skid_reg: RTL and testbench
==================================

// Module: ex_mem_skid_reg
// PURPOSE
//  EX->MEM pipeline register with valid/ready handshake and a 2-entry skid buffer (main + skid).
//  Upstream stalls are not combinationally coupled to downstream backpressure.
//  Registers store byte-lane strobes and lane-aligned store data for XLEN=32/64.
//  Flags misaligned memory accesses and suppresses their writes.
//  Sits between the ALU/EX stage and data memory; replaces the fixed 32-bit EX/MEM latch.
// PARAMETERS
//  XLEN    32   datapath width; legal values 32 or 64
//  NB      XLEN/8  byte lanes (derived localparam; not overridable)
//  CTRL_W  12   width of opaque ctrl bundle (RegWrite,MemtoReg[1:0],Branch,BranchN,Jump[1:0],zero,sign,mem_rd,mem_wr,spare)
//  NOP     32'h0000_0013   instruction word presented in bubbles/reset
// PORTS
//  clk_EXMem       in   1      clock, rising edge
//  rst_EXMem       in   1      asynchronous, active-low reset
//  flush_EXMem     in   1      synchronous kill of both entries
//  in_valid        in   1      EX presents an instruction
//  in_ready        out  1      register can accept (registered, = !skid_valid)
//  in_pc/pc4/pcimm in   XLEN   PC, PC+4, PC+imm
//  in_inst         in   32     instruction word
//  in_rd           in   5      destination register
//  in_alu          in   XLEN   ALU result / effective address
//  in_rs2          in   XLEN   store source operand
//  in_size         in   2      0=byte 1=half 2=word 3=double
//  in_ctrl         in   CTRL_W control bundle, passed through unchanged
//  out_valid       out  1      MEM-side entry valid
//  out_ready       in   1      MEM accepts entry
//  out_pc/pc4/pcimm/out_inst/out_rd/out_alu/out_size/out_ctrl  out  as inputs  registered copies
//  out_wdata       out  XLEN   rs2 shifted to byte lane
//  out_wstrb       out  NB     byte write strobes (0 for non-stores)
//  out_misalign    out  1      access not naturally aligned, or size illegal for XLEN
// BEHAVIOUR
//  - Reset (async, rst_EXMem=0): out_valid=0; skid empty; in_ready=1 after deassertion.
//    All data outputs 0 except out_inst=NOP.
//  - Accept = in_valid & in_ready.
//    Entry goes to main if main empty or (out_valid & out_ready); otherwise to skid.
//  - Drain: on out_valid & out_ready, skid (if valid) moves to main the same edge.
//    Otherwise main empties unless a new entry is accepted.
//  - Simultaneous drain+accept with skid full cannot occur: in_ready=0.
//  - Latency 1 cycle when unstalled; throughput 1/cycle; no entry dropped or duplicated; order preserved.
//  - flush_EXMem=1: both valid bits cleared next edge; same-cycle accept discarded (flush wins).
//    in_ready=1 next cycle.
//  - Bubble (out_valid=0): out_inst=NOP; out_ctrl, out_wstrb, out_misalign forced 0.
//  - Lane logic computed on input, registered with entry:
//    off=in_alu[log2(NB)-1:0]; bytes=1<<in_size.
//    misalign = (off % bytes != 0) | (in_size==3 & XLEN==32), for loads and stores.
//    store (mem_wr) & !misalign: wstrb=((1<<bytes)-1)<<off; wdata=in_rs2<<(8*off).
//    store & misalign: wstrb=0, wdata=in_rs2. Non-store: wstrb=0, wdata=in_rs2.
//  - Data/ctrl fields held stable while out_valid & !out_ready.
//  - Reset mid-operation: both entries lost; no partial strobe ever visible.
// STRUCTURE
//  - Shared package: size encodings, NOP constant, ctrl bundle bit indices.
//  - Sub-module ex_mem_lane_gen (combinational strobe/wdata/misalign), instantiated once on the input side.
//  - Two identical entry registers (main, skid) plus a 2-bit occupancy state: EMPTY, ONE, TWO.
// TESTING
//  - Reset: assert rst_EXMem=0 mid-stream -> out_valid=0, out_inst=0x00000013, in_ready=1 after release.
//  - Streaming: 8 back-to-back entries, out_ready=1 -> each appears 1 cycle later, in_ready stays 1.
//  - Backpressure: out_ready=0 for 3 cycles while in_valid=1 -> skid fills, in_ready=0 from cycle 2.
//    Release -> entries emerge in order, none lost.
//  - Store lanes XLEN=32: sb, alu=0x...3, rs2=0xAB -> wstrb=4'b1000, wdata=0xAB000000.
//    sh, alu=0x...2 -> wstrb=4'b1100, wdata=rs2[15:0]<<16.
//  - Misalign: sw, alu=0x...2 -> misalign=1, wstrb=0.
//    XLEN=64 sd, alu=0x...8 -> wstrb=8'hFF, misalign=0.
//  - Flush with skid full and in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed entries never appear.

Source files
------------

// File: rtl/ex_mem_skid_reg_pkg.sv
// Shared encodings for the EX->MEM skid register: access sizes, bubble instruction,
// and bit positions inside the opaque control bundle.
package ex_mem_skid_reg_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Control bundle, MSB first: RegWrite, MemtoReg[1:0], Branch, BranchN, Jump[1:0],
  // zero, sign, mem_rd, mem_wr, spare.
  localparam int unsigned CTRL_SPARE       = 0;
  localparam int unsigned CTRL_MEM_WR      = 1;
  localparam int unsigned CTRL_MEM_RD      = 2;
  localparam int unsigned CTRL_SIGN        = 3;
  localparam int unsigned CTRL_ZERO        = 4;
  localparam int unsigned CTRL_JUMP_LO     = 5;
  localparam int unsigned CTRL_BRANCHN     = 7;
  localparam int unsigned CTRL_BRANCH      = 8;
  localparam int unsigned CTRL_MEMTOREG_LO = 9;
  localparam int unsigned CTRL_REGWRITE    = 11;

endpackage

// File: rtl/ex_mem_lane_gen.sv
// Combinational byte-lane strobe, lane-aligned store data and misalignment flag
// for one memory access.
module ex_mem_lane_gen
  import ex_mem_skid_reg_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [$clog2(XLEN/8)-1:0] off,
  input  logic [1:0]                size,
  input  logic                      store,
  input  logic [XLEN-1:0]           rs2,
  output logic [XLEN-1:0]           wdata_c,
  output logic [XLEN/8-1:0]         wstrb_c,
  output logic                      misalign_c
);

  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(NB);

  logic [NB-1:0]    base_strb;
  logic [OFF_W-1:0] size_mask;
  logic             size_illegal;
  logic             lane_ok;

  always_comb begin
    base_strb = NB'(8'h01);
    size_mask = OFF_W'(0);
    case (size)
      SIZE_B:  begin base_strb = NB'(8'h01); size_mask = OFF_W'(0); end
      SIZE_H:  begin base_strb = NB'(8'h03); size_mask = OFF_W'(1); end
      SIZE_W:  begin base_strb = NB'(8'h0F); size_mask = OFF_W'(3); end
      default: begin base_strb = NB'(8'hFF); size_mask = OFF_W'(7); end
    endcase
  end

  // Doubleword accesses do not exist on a 32-bit datapath.
  assign size_illegal = (size == SIZE_D) && (XLEN == 32);
  assign misalign_c   = ((off & size_mask) != '0) || size_illegal;
  assign lane_ok      = store && !misalign_c;

  assign wstrb_c = lane_ok ? (base_strb << off) : '0;
  assign wdata_c = lane_ok ? (rs2 << {off, 3'b000}) : rs2;

endmodule

// File: rtl/ex_mem_skid_reg.sv
// EX->MEM pipeline register with a main entry and a skid entry so that in_ready
// depends only on local state, never on out_ready in the same cycle.
module ex_mem_skid_reg
  import ex_mem_skid_reg_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = 12,
  parameter logic [31:0] NOP    = NOP_INST
) (
  input  logic                clk_EXMem,
  input  logic                rst_EXMem,
  input  logic                flush_EXMem,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in_pc,
  input  logic [XLEN-1:0]     in_pc4,
  input  logic [XLEN-1:0]     in_pcimm,
  input  logic [31:0]         in_inst,
  input  logic [4:0]          in_rd,
  input  logic [XLEN-1:0]     in_alu,
  input  logic [XLEN-1:0]     in_rs2,
  input  logic [1:0]          in_size,
  input  logic [CTRL_W-1:0]   in_ctrl,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic [XLEN-1:0]     out_pc4,
  output logic [XLEN-1:0]     out_pcimm,
  output logic [31:0]         out_inst,
  output logic [4:0]          out_rd,
  output logic [XLEN-1:0]     out_alu,
  output logic [1:0]          out_size,
  output logic [CTRL_W-1:0]   out_ctrl,
  output logic [XLEN-1:0]     out_wdata,
  output logic [XLEN/8-1:0]   out_wstrb,
  output logic                out_misalign
);

  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(NB);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc4;
    logic [XLEN-1:0]   pcimm;
    logic [31:0]       inst;
    logic [4:0]        rd;
    logic [XLEN-1:0]   alu;
    logic [1:0]        size;
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   wdata;
    logic [NB-1:0]     wstrb;
    logic              misalign;
  } entry_t;

  // A drained main entry keeps its data but shows NOP and no side effects.
  function automatic entry_t to_bubble(entry_t e);
    entry_t b;
    b          = e;
    b.inst     = NOP;
    b.ctrl     = '0;
    b.wstrb    = '0;
    b.misalign = 1'b0;
    return b;
  endfunction

  function automatic entry_t reset_entry();
    entry_t e;
    e      = '0;
    e.inst = NOP;
    return e;
  endfunction

  logic [1:0]      state_q, state_d;
  entry_t          main_q, main_d;
  entry_t          skid_q, skid_d;
  entry_t          in_entry;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            accept, drain;
  logic [XLEN-1:0] lane_wdata;
  logic [NB-1:0]   lane_wstrb;
  logic            lane_misalign;

  ex_mem_lane_gen #(.XLEN(XLEN)) u_lane_gen (
    .off        (in_alu[OFF_W-1:0]),
    .size       (in_size),
    .store      (in_ctrl[CTRL_MEM_WR]),
    .rs2        (in_rs2),
    .wdata_c    (lane_wdata),
    .wstrb_c    (lane_wstrb),
    .misalign_c (lane_misalign)
  );

  always_comb begin
    in_entry          = '0;
    in_entry.pc       = in_pc;
    in_entry.pc4      = in_pc4;
    in_entry.pcimm    = in_pcimm;
    in_entry.inst     = in_inst;
    in_entry.rd       = in_rd;
    in_entry.alu      = in_alu;
    in_entry.size     = in_size;
    in_entry.ctrl     = in_ctrl;
    in_entry.wdata    = lane_wdata;
    in_entry.wstrb    = lane_wstrb;
    in_entry.misalign = lane_misalign;
  end

  // Occupancy FSM and entry movement; flush overrides any same-cycle accept.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    accept  = in_valid && in_ready_q && !flush_EXMem;
    drain   = out_valid_q && out_ready;
    if (flush_EXMem) begin
      state_d = ST_EMPTY;
      main_d  = to_bubble(main_q);
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            main_d  = in_entry;
          end
        end
        ST_ONE: begin
          if (drain && accept) begin
            main_d = in_entry;
          end else if (drain) begin
            state_d = ST_EMPTY;
            main_d  = to_bubble(main_q);
          end else if (accept) begin
            state_d = ST_TWO;
            skid_d  = in_entry;
          end
        end
        ST_TWO: begin
          if (drain) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = to_bubble(main_q);
        end
      endcase
    end
    in_ready_d  = (state_d != ST_TWO);
    out_valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge clk_EXMem or negedge rst_EXMem) begin
    if (!rst_EXMem) begin
      state_q     <= ST_EMPTY;
      main_q      <= reset_entry();
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_pc       = main_q.pc;
  assign out_pc4      = main_q.pc4;
  assign out_pcimm    = main_q.pcimm;
  assign out_inst     = main_q.inst;
  assign out_rd       = main_q.rd;
  assign out_alu      = main_q.alu;
  assign out_size     = main_q.size;
  assign out_ctrl     = main_q.ctrl;
  assign out_wdata    = main_q.wdata;
  assign out_wstrb    = main_q.wstrb;
  assign out_misalign = main_q.misalign;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Directed bench for ex_mem_skid_reg: reset, streaming, backpressure, lane logic
// on XLEN=32 and XLEN=64 instances, flush and mid-stream reset.
module tb_ex_mem_skid_reg;
  import ex_mem_skid_reg_pkg::*;

  localparam logic [11:0] CT_ALU = 12'h800;
  localparam logic [11:0] CT_ST  = 12'(1 << CTRL_MEM_WR);
  localparam logic [11:0] CT_LD  = 12'h800 | 12'(1 << CTRL_MEM_RD);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_pc = '0, in_pc4 = '0, in_pcimm = '0, in_inst = '0, in_alu = '0, in_rs2 = '0;
  logic [4:0]  in_rd = '0;
  logic [1:0]  in_size = '0;
  logic [11:0] in_ctrl = '0;
  logic        out_valid, out_ready = 1'b1, out_misalign;
  logic [31:0] out_pc, out_pc4, out_pcimm, out_inst, out_alu, out_wdata;
  logic [4:0]  out_rd;
  logic [1:0]  out_size;
  logic [11:0] out_ctrl;
  logic [3:0]  out_wstrb;

  logic        d_in_valid = 1'b0, d_in_ready, d_out_valid, d_out_misalign;
  logic [63:0] d_in_alu = '0, d_in_rs2 = '0;
  logic [1:0]  d_in_size = '0, d_out_size;
  logic [11:0] d_in_ctrl = '0, d_out_ctrl;
  logic [63:0] d_out_pc, d_out_pc4, d_out_pcimm, d_out_alu, d_out_wdata;
  logic [31:0] d_out_inst;
  logic [4:0]  d_out_rd;
  logic [7:0]  d_out_wstrb;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ex_mem_skid_reg #(.XLEN(32)) dut (
    .clk_EXMem(clk), .rst_EXMem(rst), .flush_EXMem(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_pc4(in_pc4), .in_pcimm(in_pcimm), .in_inst(in_inst),
    .in_rd(in_rd), .in_alu(in_alu), .in_rs2(in_rs2), .in_size(in_size), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pc4(out_pc4), .out_pcimm(out_pcimm), .out_inst(out_inst),
    .out_rd(out_rd), .out_alu(out_alu), .out_size(out_size), .out_ctrl(out_ctrl),
    .out_wdata(out_wdata), .out_wstrb(out_wstrb), .out_misalign(out_misalign)
  );

  ex_mem_skid_reg #(.XLEN(64)) dut64 (
    .clk_EXMem(clk), .rst_EXMem(rst), .flush_EXMem(1'b0),
    .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_pc(64'h0), .in_pc4(64'h4), .in_pcimm(64'h0), .in_inst(32'h0000_3023),
    .in_rd(5'd0), .in_alu(d_in_alu), .in_rs2(d_in_rs2), .in_size(d_in_size), .in_ctrl(d_in_ctrl),
    .out_valid(d_out_valid), .out_ready(1'b1),
    .out_pc(d_out_pc), .out_pc4(d_out_pc4), .out_pcimm(d_out_pcimm), .out_inst(d_out_inst),
    .out_rd(d_out_rd), .out_alu(d_out_alu), .out_size(d_out_size), .out_ctrl(d_out_ctrl),
    .out_wdata(d_out_wdata), .out_wstrb(d_out_wstrb), .out_misalign(d_out_misalign)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] alu,
                       input logic [31:0] rs2, input logic [1:0] size, input logic [11:0] ctrl);
    in_valid = 1'b1;
    in_pc    = pc;
    in_pc4   = pc + 32'd4;
    in_pcimm = pc + 32'h40;
    in_inst  = inst;
    in_rd    = pc[6:2];
    in_alu   = alu;
    in_rs2   = rs2;
    in_size  = size;
    in_ctrl  = ctrl;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_inst",  64'(out_inst),  64'h13);
    check("rst_out_pc",    64'(out_pc),    64'd0);
    check("rst_out_wstrb", 64'(out_wstrb), 64'd0);
    rst = 1'b1;
    step();
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Streaming: each entry visible one edge after acceptance.
    for (int i = 0; i < 8; i++) begin
      drive(32'h100 + 32'(i * 4), 32'h0000_0033 | 32'(i << 7), 32'h2000 + 32'(i * 4),
            32'(i), SIZE_W, CT_ALU);
      step();
      check("stream_valid",    64'(out_valid), 64'd1);
      check("stream_pc",       64'(out_pc),    64'(32'h100 + 32'(i * 4)));
      check("stream_inst",     64'(out_inst),  64'(32'h0000_0033 | 32'(i << 7)));
      check("stream_in_ready", 64'(in_ready),  64'd1);
    end
    in_valid = 1'b0;
    step();
    check("bubble_valid", 64'(out_valid), 64'd0);
    check("bubble_inst",  64'(out_inst),  64'h13);
    check("bubble_ctrl",  64'(out_ctrl),  64'd0);

    // Backpressure: A to main, B to skid, C held off until space frees.
    out_ready = 1'b0;
    drive(32'h200, 32'h0000_0A33, 32'h0, 32'h0, SIZE_W, CT_ALU);
    step();
    check("bp_a_pc",     64'(out_pc),   64'h200);
    check("bp_ready1",   64'(in_ready), 64'd1);
    drive(32'h204, 32'h0000_0B33, 32'h0, 32'h0, SIZE_W, CT_ALU);
    step();
    check("bp_ready2",   64'(in_ready), 64'd0);
    check("bp_hold_pc",  64'(out_pc),   64'h200);
    drive(32'h208, 32'h0000_0C33, 32'h0, 32'h0, SIZE_W, CT_ALU);
    step();
    check("bp_ready3",   64'(in_ready), 64'd0);
    check("bp_hold_pc3", 64'(out_pc),   64'h200);
    check("bp_hold_v3",  64'(out_valid), 64'd1);
    out_ready = 1'b1;
    step();
    check("bp_b_pc",     64'(out_pc),   64'h204);
    check("bp_ready4",   64'(in_ready), 64'd1);
    step();
    check("bp_c_pc",     64'(out_pc),   64'h208);
    check("bp_c_valid",  64'(out_valid), 64'd1);
    in_valid = 1'b0;
    step();
    check("bp_drained",  64'(out_valid), 64'd0);

    // Lane logic on the 32-bit instance.
    drive(32'h300, 32'h0000_0023, 32'h0000_1003, 32'h0000_00AB, SIZE_B, CT_ST);
    step();
    check("sb_wstrb",    64'(out_wstrb),    64'h8);
    check("sb_wdata",    64'(out_wdata),    64'hAB00_0000);
    check("sb_misalign", 64'(out_misalign), 64'd0);
    drive(32'h304, 32'h0000_1023, 32'h0000_2002, 32'h1234_CDEF, SIZE_H, CT_ST);
    step();
    check("sh_wstrb",    64'(out_wstrb),    64'hC);
    check("sh_wdata",    64'(out_wdata),    64'hCDEF_0000);
    drive(32'h308, 32'h0000_2023, 32'h0000_3002, 32'h5566_7788, SIZE_W, CT_ST);
    step();
    check("sw_mis_flag",  64'(out_misalign), 64'd1);
    check("sw_mis_wstrb", 64'(out_wstrb),    64'd0);
    check("sw_mis_wdata", 64'(out_wdata),    64'h5566_7788);
    drive(32'h30C, 32'h0000_1003, 32'h0000_4001, 32'h0, SIZE_H, CT_LD);
    step();
    check("lh_mis_flag",  64'(out_misalign), 64'd1);
    check("lh_mis_wstrb", 64'(out_wstrb),    64'd0);
    drive(32'h310, 32'h0000_3023, 32'h0000_5000, 32'h1, SIZE_D, CT_ST);
    step();
    check("sd32_illegal", 64'(out_misalign), 64'd1);
    check("sd32_wstrb",   64'(out_wstrb),    64'd0);
    drive(32'h314, 32'h0000_2023, 32'h0000_6004, 32'h0000_0077, SIZE_W, CT_ALU);
    step();
    check("nonstore_wstrb", 64'(out_wstrb), 64'd0);
    check("nonstore_wdata", 64'(out_wdata), 64'h77);
    in_valid = 1'b0;

    // Lane logic on the 64-bit instance.
    d_in_valid = 1'b1;
    d_in_alu   = 64'h1008;
    d_in_rs2   = 64'h1122_3344_5566_7788;
    d_in_size  = SIZE_D;
    d_in_ctrl  = CT_ST;
    step();
    check("sd64_wstrb",    64'(d_out_wstrb),    64'hFF);
    check("sd64_misalign", 64'(d_out_misalign), 64'd0);
    check("sd64_wdata",    d_out_wdata,         64'h1122_3344_5566_7788);
    d_in_alu  = 64'h2004;
    d_in_rs2  = 64'h0000_0000_DEAD_BEEF;
    d_in_size = SIZE_W;
    step();
    check("sw64_wstrb", 64'(d_out_wstrb), 64'hF0);
    check("sw64_wdata", d_out_wdata,      64'hDEAD_BEEF_0000_0000);
    d_in_valid = 1'b0;
    step();
    check("d64_drained", 64'(d_out_valid), 64'd0);

    // Flush with skid full and a new entry offered in the same cycle.
    out_ready = 1'b0;
    drive(32'h400, 32'h0000_0D33, 32'h0, 32'h0, SIZE_W, CT_ALU);
    step();
    drive(32'h404, 32'h0000_0E33, 32'h0, 32'h0, SIZE_W, CT_ALU);
    step();
    check("fl_full", 64'(in_ready), 64'd0);
    drive(32'h408, 32'h0000_0F33, 32'h0, 32'h0, SIZE_W, CT_ALU);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_ready", 64'(in_ready),  64'd1);
    check("fl_inst",  64'(out_inst),  64'h13);
    out_ready = 1'b1;
    step();
    check("fl_no_ghost", 64'(out_valid), 64'd0);
    drive(32'h40C, 32'h0000_1133, 32'h0, 32'h0, SIZE_W, CT_ALU);
    step();
    check("fl_next_valid", 64'(out_valid), 64'd1);
    check("fl_next_pc",    64'(out_pc),    64'h40C);
    in_valid = 1'b0;
    step();
    check("fl_empty", 64'(out_valid), 64'd0);

    // Asynchronous reset with both entries holding stores.
    out_ready = 1'b0;
    drive(32'h500, 32'h0000_2023, 32'h0000_7000, 32'h1, SIZE_W, CT_ST);
    step();
    check("mr_pre_wstrb", 64'(out_wstrb), 64'hF);
    drive(32'h504, 32'h0000_2023, 32'h0000_7004, 32'h2, SIZE_W, CT_ST);
    step();
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("mr_valid", 64'(out_valid), 64'd0);
    check("mr_inst",  64'(out_inst),  64'h13);
    check("mr_wstrb", 64'(out_wstrb), 64'd0);
    @(negedge clk);
    rst       = 1'b1;
    out_ready = 1'b1;
    step();
    check("mr_ready_after", 64'(in_ready),  64'd1);
    check("mr_valid_after", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
